// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: drives the instruction_bank FetchAction, buffers {pc, inst} in a skid FIFO toward decode, and turns execute redirects into a bank restart pulse.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_stalls / perf_redirects counters.
package proctypes;
    typedef logic [31:0] InstructionAddr;
    typedef logic [15:0] Instruction;
    typedef enum logic { fetchStall = 1'b0, fetchDequeue = 1'b1 } FetchAction;
endpackage

module fetch_sequencer
    import proctypes::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bank_valid,
    input  InstructionAddr bank_pc,
    input  Instruction     bank_inst,
    output FetchAction     bank_action,
    output logic           fetch_redirect,
    output InstructionAddr fetch_target,
    input  logic           redirect_valid,
    input  InstructionAddr redirect_pc,
    input  logic           halt_req,
    output logic           dec_valid,
    output InstructionAddr dec_pc,
    output Instruction     dec_inst,
`ifdef FETCH_PERF_EN
    output logic [31:0]    perf_fetched,
    output logic [31:0]    perf_stalls,
    output logic [15:0]    perf_redirects,
`endif
    input  logic           dec_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] { S_RUN, S_REDIR, S_WAIT, S_HALT } state_t;

    state_t         state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    InstructionAddr pc_mem   [DEPTH];
    Instruction     inst_mem [DEPTH];
    logic           push, pop;

    // The dequeue decision never looks at dec_ready, so a full FIFO stalls the bank even when decode pops.
    always_comb begin
        state_nxt   = state;
        bank_action = fetchStall;
        case (state)
            S_RUN: begin
                if (bank_valid && (count < CNT_W'(DEPTH)) && !redirect_valid)
                    bank_action = fetchDequeue;
                if (halt_req)
                    state_nxt = S_HALT;
            end
            S_REDIR: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = halt_req ? S_HALT : S_RUN;
            S_HALT: begin
                if (!halt_req)
                    state_nxt = S_RUN;
            end
        endcase
        if (redirect_valid)
            state_nxt = S_REDIR;
        if (!rst)
            bank_action = fetchStall;
    end

    assign push           = (bank_action == fetchDequeue);
    assign dec_valid      = (count != '0);
    assign pop            = dec_valid && dec_ready;
    assign fetch_redirect = (state == S_REDIR);
    assign dec_pc         = pc_mem[rd_ptr];
    assign dec_inst       = inst_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RUN;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fetch_target <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                // Flush wins over any handshake completing this cycle.
                fetch_target <= redirect_pc;
                count        <= '0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]   <= bank_pc;
                    inst_mem[wr_ptr] <= bank_inst;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched   <= '0;
            perf_stalls    <= '0;
            perf_redirects <= '0;
        end else begin
            if (push)
                perf_fetched <= perf_fetched + 1'b1;
            if ((state == S_RUN) && bank_valid && !push)
                perf_stalls <= perf_stalls + 1'b1;
            if (redirect_valid)
                perf_redirects <= perf_redirects + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of per-cycle inputs and expected outputs, plus an async-reset sequence.
module tb_fetch_sequencer;
    import proctypes::*;

    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           bank_valid = 1'b1;
    InstructionAddr bank_pc = '0;
    Instruction     bank_inst;
    FetchAction     bank_action;
    logic           fetch_redirect;
    InstructionAddr fetch_target;
    logic           redirect_valid = 1'b0;
    InstructionAddr redirect_pc = '0;
    logic           halt_req = 1'b0;
    logic           dec_valid;
    InstructionAddr dec_pc;
    Instruction     dec_inst;
    logic           dec_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0]    perf_fetched;
    logic [31:0]    perf_stalls;
    logic [15:0]    perf_redirects;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic Instruction inst_of(input InstructionAddr pc);
        return pc[15:0] ^ 16'hA5A5;
    endfunction

    assign bank_inst = inst_of(bank_pc);

    fetch_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .bank_valid(bank_valid), .bank_pc(bank_pc), .bank_inst(bank_inst),
        .bank_action(bank_action), .fetch_redirect(fetch_redirect), .fetch_target(fetch_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_stalls(perf_stalls), .perf_redirects(perf_redirects),
`endif
        .dec_ready(dec_ready)
    );

    typedef struct {
        logic           bv;
        InstructionAddr bpc;
        logic           rv;
        InstructionAddr rpc;
        logic           halt;
        logic           rdy;
        FetchAction     act;
        logic           frd;
        InstructionAddr tgt;
        logic           dv;
        InstructionAddr dpc;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic bv, input InstructionAddr bpc, input logic rv, input InstructionAddr rpc,
                     input logic halt, input logic rdy, input FetchAction act, input logic frd,
                     input InstructionAddr tgt, input logic dv, input InstructionAddr dpc);
        vec_t e;
        e.bv = bv; e.bpc = bpc; e.rv = rv; e.rpc = rpc; e.halt = halt; e.rdy = rdy;
        e.act = act; e.frd = frd; e.tgt = tgt; e.dv = dv; e.dpc = dpc;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    localparam FetchAction D = fetchDequeue;
    localparam FetchAction S = fetchStall;

    initial begin
        // Stream, then backpressure
        v(1, 'h000, 0, 0, 0, 1, D, 0, 0, 0, 'h000);
        v(1, 'h002, 0, 0, 0, 1, D, 0, 0, 1, 'h000);
        v(1, 'h004, 0, 0, 0, 1, D, 0, 0, 1, 'h002);
        v(1, 'h006, 0, 0, 0, 1, D, 0, 0, 1, 'h004);
        v(1, 'h008, 0, 0, 0, 0, D, 0, 0, 1, 'h006);
        for (int k = 0; k < 4; k++)
            v(1, 'h00A, 0, 0, 0, 0, S, 0, 0, 1, 'h006);
        v(1, 'h00A, 0, 0, 0, 1, S, 0, 0, 1, 'h006);
        v(1, 'h00A, 0, 0, 0, 1, D, 0, 0, 1, 'h008);
        v(1, 'h00C, 0, 0, 0, 1, D, 0, 0, 1, 'h00A);
        // Redirect with two entries buffered
        v(1, 'h00E, 0, 0, 0, 0, D, 0, 0, 1, 'h00C);
        v(1, 'h010, 1, 'h100, 0, 0, S, 0, 0, 1, 'h00C);
        v(1, 'h010, 0, 0, 0, 1, S, 1, 'h100, 0, 0);
        v(1, 'h100, 0, 0, 0, 1, S, 0, 0, 0, 0);
        v(1, 'h100, 0, 0, 0, 1, D, 0, 0, 0, 0);
        v(1, 'h102, 0, 0, 0, 1, D, 0, 0, 1, 'h100);
        // Back-to-back redirects
        v(1, 'h104, 1, 'h040, 0, 1, S, 0, 0, 1, 'h102);
        v(1, 'h104, 1, 'h080, 0, 1, S, 1, 'h040, 0, 0);
        v(1, 'h040, 0, 0, 0, 1, S, 1, 'h080, 0, 0);
        v(1, 'h080, 0, 0, 0, 1, S, 0, 0, 0, 0);
        v(1, 'h080, 0, 0, 0, 1, D, 0, 0, 0, 0);
        v(1, 'h082, 0, 0, 0, 1, D, 0, 0, 1, 'h080);
        // Halt for four cycles while the FIFO drains
        v(0, 'h084, 0, 0, 1, 0, S, 0, 0, 1, 'h082);
        v(1, 'h084, 0, 0, 1, 1, S, 0, 0, 1, 'h082);
        v(1, 'h084, 0, 0, 1, 1, S, 0, 0, 0, 0);
        v(1, 'h084, 0, 0, 1, 1, S, 0, 0, 0, 0);
        v(1, 'h084, 0, 0, 0, 1, S, 0, 0, 0, 0);
        v(1, 'h084, 0, 0, 0, 1, D, 0, 0, 0, 0);
        v(0, 'h086, 0, 0, 0, 1, S, 0, 0, 1, 'h084);
        // Redirect takes priority over a simultaneous halt
        v(1, 'h088, 1, 'h200, 1, 1, S, 0, 0, 0, 0);
        v(1, 'h088, 0, 0, 1, 1, S, 1, 'h200, 0, 0);
        v(1, 'h088, 0, 0, 1, 1, S, 0, 0, 0, 0);
        v(1, 'h200, 0, 0, 0, 1, S, 0, 0, 0, 0);
        v(1, 'h200, 0, 0, 0, 1, D, 0, 0, 0, 0);
        v(0, 'h202, 0, 0, 0, 1, S, 0, 0, 1, 'h200);

        // Reset state, with the bank offering an instruction
        #12;
        check("rst action", 32'(bank_action), 32'(S));
        check("rst dec_valid", 32'(dec_valid), 0);
        check("rst fetch_redirect", 32'(fetch_redirect), 0);
        check("rst fetch_target", fetch_target, 0);
        check("rst dec_pc", dec_pc, 0);
        check("rst dec_inst", 32'(dec_inst), 0);
        bank_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bank_valid     = vecs[i].bv;
            bank_pc        = vecs[i].bpc;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            halt_req       = vecs[i].halt;
            dec_ready      = vecs[i].rdy;
            #1;
            check($sformatf("v%0d action", i), 32'(bank_action), 32'(vecs[i].act));
            check($sformatf("v%0d fetch_redirect", i), 32'(fetch_redirect), 32'(vecs[i].frd));
            check($sformatf("v%0d dec_valid", i), 32'(dec_valid), 32'(vecs[i].dv));
            if (vecs[i].frd)
                check($sformatf("v%0d fetch_target", i), fetch_target, vecs[i].tgt);
            if (vecs[i].dv) begin
                check($sformatf("v%0d dec_pc", i), dec_pc, vecs[i].dpc);
                check($sformatf("v%0d dec_inst", i), 32'(dec_inst), 32'(inst_of(vecs[i].dpc)));
            end
        end

        @(negedge clk);
        bank_valid = 1'b0;
        halt_req   = 1'b0;
        dec_ready  = 1'b0;
        redirect_valid = 1'b0;
`ifdef FETCH_PERF_EN
        @(negedge clk);
        #1;
        check("perf_fetched", perf_fetched, 14);
        check("perf_stalls", perf_stalls, 8);
        check("perf_redirects", 32'(perf_redirects), 4);
`endif

        // Asynchronous reset in the middle of a redirect
        @(negedge clk);
        bank_valid = 1'b1;
        bank_pc    = 'h500;
        @(negedge clk);
        #1;
        check("pre-reset dec_valid", 32'(dec_valid), 1);
        check("pre-reset dec_pc", dec_pc, 'h500);
        redirect_valid = 1'b1;
        redirect_pc    = 'h300;
        bank_pc        = 'h502;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("pre-reset fetch_redirect", 32'(fetch_redirect), 1);
        check("pre-reset fetch_target", fetch_target, 'h300);
        rst = 1'b0;
        #1;
        check("async fetch_redirect", 32'(fetch_redirect), 0);
        check("async fetch_target", fetch_target, 0);
        check("async dec_valid", 32'(dec_valid), 0);
        check("async dec_pc", dec_pc, 0);
        check("async action", 32'(bank_action), 32'(S));
        #1;
        rst = 1'b1;
        #1;
        check("release action", 32'(bank_action), 32'(D));
        check("release fetch_redirect", 32'(fetch_redirect), 0);
        @(negedge clk);
        bank_valid = 1'b0;
        #1;
        check("post-release fetch_redirect", 32'(fetch_redirect), 0);
        check("post-release dec_valid", 32'(dec_valid), 1);
        check("post-release dec_pc", dec_pc, 'h502);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
